// File: rtl/jpeg_bs_pkg.sv
// Shared constants, state encoding and width helper for the JPEG bitstream reader.
package jpeg_bs_pkg;

    localparam logic [7:0] MK_SOI  = 8'hD8;
    localparam logic [7:0] MK_EOI  = 8'hD9;
    localparam logic [7:0] MK_RST0 = 8'hD0;
    localparam logic [7:0] MK_RST7 = 8'hD7;
    localparam logic [7:0] STUFF   = 8'h00;
    localparam logic [7:0] FILL    = 8'hFF;

    typedef enum logic [1:0] {
        DATA        = 2'd0,
        SEEN_FF     = 2'd1,
        MARKER_HOLD = 2'd2
    } bs_state_e;

    // Bits needed to count 0..buf_w inclusive.
    function automatic int avail_w(input int buf_w);
        return $clog2(buf_w) + 1;
    endfunction

endpackage

// File: rtl/jpeg_bit_shifter.sv
// MSB-aligned bit buffer: shift left by the consumed length, then append a
// byte directly behind the surviving bits. Bits below the valid region are
// always zero, so the window reads 0 beyond avail without extra masking.
module jpeg_bit_shifter
    import jpeg_bs_pkg::*;
#(
    parameter int BUF_W = 32,
    parameter int WIN_W = 16,
    localparam int AW   = avail_w(BUF_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [AW-1:0]    shift_len,
    input  logic             append_en,
    input  logic [7:0]       append_byte,
    output logic [WIN_W-1:0] win,
    output logic [AW-1:0]    avail
);

    logic [BUF_W-1:0] bits, bits_n, placed;
    logic [AW-1:0]    kept, avail_n;

    // Combined shift/append; append offset uses the post-shift bit count.
    always_comb begin
        kept    = avail - shift_len;
        placed  = BUF_W'(append_byte) << (AW'(BUF_W - 8) - kept);
        bits_n  = (bits << shift_len) | (append_en ? placed : '0);
        avail_n = kept + (append_en ? AW'(8) : '0);
    end

    // Buffer and fill level; clear drops everything (marker release).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits  <= '0;
            avail <= '0;
        end else if (clear) begin
            bits  <= '0;
            avail <= '0;
        end else begin
            bits  <= bits_n;
            avail <= avail_n;
        end
    end

    assign win = bits[BUF_W-1 -: WIN_W];

endmodule

// File: rtl/jpeg_bitstream_reader.sv
// JPEG entropy-segment reader: removes 0xFF00 stuffing, skips 0xFF fill,
// holds markers for the controller and feeds a lookahead window to the
// Huffman decoder. Optional macro JPEG_RST_MARKER_PASS_EN lets RST0..RST7
// pass inline (byte-align + rst_seen pulse) instead of stalling.
module jpeg_bitstream_reader
    import jpeg_bs_pkg::*;
#(
    parameter int BUF_W = 32,
    parameter int WIN_W = 16,
    localparam int AW   = avail_w(BUF_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIN_W-1:0] win_data,
    output logic [AW-1:0]    win_avail,
    input  logic             consume_valid,
    input  logic [4:0]       consume_len,
    output logic             marker_valid,
    output logic [7:0]       marker_code,
    input  logic             marker_ack,
`ifdef JPEG_RST_MARKER_PASS_EN
    output logic             rst_seen,
    output logic [2:0]       rst_idx,
`endif
    output logic             protocol_err
);

    bs_state_e     state, state_n;
    logic          run;
    logic          accept, ack, len_fits, cons_ok;
    logic          append_en, take_marker;
    logic [7:0]    append_byte;
    logic [AW-1:0] len_ext, cons_len, shift_len;
`ifdef JPEG_RST_MARKER_PASS_EN
    logic          rst_hit;
    logic [AW-1:0] kept;
`endif

    // Ready depends only on registered state, never on this cycle's consume.
    assign in_ready     = run && (state != MARKER_HOLD) && (win_avail <= AW'(BUF_W - 8));
    assign accept       = in_valid && in_ready;
    assign ack          = marker_ack && (state == MARKER_HOLD);
    assign len_ext      = AW'(consume_len);
    assign len_fits     = len_ext <= win_avail;
    assign cons_ok      = consume_valid && !ack && len_fits;
    assign cons_len     = cons_ok ? len_ext : '0;
    assign marker_valid = (state == MARKER_HOLD);

    // Next-state and append control for the destuffing FSM.
    always_comb begin
        state_n     = state;
        append_en   = 1'b0;
        append_byte = in_data;
        take_marker = 1'b0;
`ifdef JPEG_RST_MARKER_PASS_EN
        rst_hit     = 1'b0;
`endif
        case (state)
            DATA: begin
                if (accept) begin
                    if (in_data == FILL) state_n   = SEEN_FF;
                    else                 append_en = 1'b1;
                end
            end
            SEEN_FF: begin
                if (accept) begin
                    if (in_data == STUFF) begin
                        append_en   = 1'b1;
                        append_byte = FILL;
                        state_n     = DATA;
                    end else if (in_data != FILL) begin
`ifdef JPEG_RST_MARKER_PASS_EN
                        if (in_data >= MK_RST0 && in_data <= MK_RST7) begin
                            rst_hit = 1'b1;
                            state_n = DATA;
                        end else begin
                            take_marker = 1'b1;
                            state_n     = MARKER_HOLD;
                        end
`else
                        take_marker = 1'b1;
                        state_n     = MARKER_HOLD;
`endif
                    end
                end
            end
            MARKER_HOLD: begin
                if (ack) state_n = DATA;
            end
            default: state_n = DATA;
        endcase
    end

    // Shift amount: consumed bits, plus the partial-byte remainder on RSTn.
    always_comb begin
`ifdef JPEG_RST_MARKER_PASS_EN
        kept      = win_avail - cons_len;
        shift_len = cons_len + (rst_hit ? AW'(kept[2:0]) : '0);
`else
        shift_len = cons_len;
`endif
    end

    jpeg_bit_shifter #(.BUF_W(BUF_W), .WIN_W(WIN_W)) u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (ack),
        .shift_len   (shift_len),
        .append_en   (append_en),
        .append_byte (append_byte),
        .win         (win_data),
        .avail       (win_avail)
    );

    // FSM state, intake enable, marker code and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= DATA;
            run          <= 1'b0;
            marker_code  <= 8'h00;
            protocol_err <= 1'b0;
        end else begin
            state <= state_n;
            run   <= 1'b1;
            if (take_marker) marker_code <= in_data;
            if (consume_valid && !ack && !len_fits) protocol_err <= 1'b1;
        end
    end

`ifdef JPEG_RST_MARKER_PASS_EN
    // One-cycle restart pulse and its index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_seen <= 1'b0;
            rst_idx  <= 3'd0;
        end else begin
            rst_seen <= rst_hit;
            if (rst_hit) rst_idx <= in_data[2:0];
        end
    end
`endif

endmodule

// File: tb/tb_jpeg_bitstream_reader.sv
// Self-checking bench for jpeg_bitstream_reader: directed steps followed by a
// random phase, all compared against a bit-queue model of the byte stream.
module tb_jpeg_bitstream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] win_data;
    logic [5:0]  win_avail;
    logic        consume_valid = 1'b0;
    logic [4:0]  consume_len = 5'd0;
    logic        marker_valid;
    logic [7:0]  marker_code;
    logic        marker_ack = 1'b0;
    logic        protocol_err;
`ifdef JPEG_RST_MARKER_PASS_EN
    logic        rst_seen;
    logic [2:0]  rst_idx;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model: destuffed stream as a queue of bits, head = next bit.
    bit         q[$];
    int         m_mode = 0;      // 0 normal, 1 after 0xFF, 2 marker pending
    bit         m_started = 0;
    bit         m_err = 0;
    logic [7:0] m_code = 8'h00;
    bit         m_rst = 0;
    logic [2:0] m_idx = 3'd0;

    jpeg_bitstream_reader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .win_data      (win_data),
        .win_avail     (win_avail),
        .consume_valid (consume_valid),
        .consume_len   (consume_len),
        .marker_valid  (marker_valid),
        .marker_code   (marker_code),
        .marker_ack    (marker_ack),
`ifdef JPEG_RST_MARKER_PASS_EN
        .rst_seen      (rst_seen),
        .rst_idx       (rst_idx),
`endif
        .protocol_err  (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_win();
        logic [15:0] w = 16'h0;
        for (int i = 0; i < 16 && i < q.size(); i++) w[15-i] = q[i];
        return w;
    endfunction

    function automatic bit m_ready();
        return m_started && (m_mode != 2) && (q.size() <= 24);
    endfunction

    task automatic m_reset();
        q.delete();
        m_mode = 0; m_started = 0; m_err = 0; m_code = 8'h00; m_rst = 0; m_idx = 3'd0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) q.push_back(b[i]);
    endtask

    task automatic drop(input int n);
        repeat (n) void'(q.pop_front());
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic m_step();
        bit take, ak;
        take  = in_valid && m_ready();
        ak    = marker_ack && (m_mode == 2);
        m_rst = 0;
        if (consume_valid && !ak) begin
            if (int'(consume_len) <= q.size()) drop(int'(consume_len));
            else m_err = 1;
        end
        if (take) begin
            if (m_mode == 0) begin
                if (in_data == 8'hFF) m_mode = 1;
                else push_byte(in_data);
            end else if (m_mode == 1) begin
                if (in_data == 8'h00) begin
                    push_byte(8'hFF);
                    m_mode = 0;
                end else if (in_data != 8'hFF) begin
`ifdef JPEG_RST_MARKER_PASS_EN
                    if (in_data >= 8'hD0 && in_data <= 8'hD7) begin
                        drop(q.size() % 8);
                        m_rst = 1;
                        m_idx = in_data[2:0];
                        m_mode = 0;
                    end else begin
                        m_code = in_data;
                        m_mode = 2;
                    end
`else
                    m_code = in_data;
                    m_mode = 2;
`endif
                end
            end
        end
        if (ak) begin
            q.delete();
            m_mode = 0;
        end
        m_started = 1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".avail"}, 32'(win_avail), 32'(q.size()));
        check({tag, ".win"}, 32'(win_data), 32'(m_win()));
        check({tag, ".ready"}, 32'(in_ready), 32'(m_ready()));
        check({tag, ".mvalid"}, 32'(marker_valid), 32'(m_mode == 2));
        check({tag, ".mcode"}, 32'(marker_code), 32'(m_code));
        check({tag, ".err"}, 32'(protocol_err), 32'(m_err));
`ifdef JPEG_RST_MARKER_PASS_EN
        check({tag, ".rst_seen"}, 32'(rst_seen), 32'(m_rst));
        check({tag, ".rst_idx"}, 32'(rst_idx), 32'(m_idx));
`endif
    endtask

    // One clock: drive inputs, take the edge, step the model, compare.
    task automatic cyc(input string tag, input bit iv, input logic [7:0] b,
                       input bit cv, input int len, input bit ak);
        in_valid = iv; in_data = b; consume_valid = cv;
        consume_len = 5'(len); marker_ack = ak;
        @(posedge clk);
        m_step();
        #1;
        check_all(tag);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (q.size() > 0 && guard < 8) begin
            cyc(tag, 0, 8'h00, 1, (q.size() < 16) ? q.size() : 16, 0);
            guard++;
        end
    endtask

    initial begin
        // Reset state
        m_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;
        #1;
        check_all("post_reset");
        cyc("idle0", 0, 8'h00, 0, 0, 0);
        check("idle0.ready_up", 32'(in_ready), 32'd1);

        // Plain bytes fill the buffer until ready drops at 32 bits
        cyc("t1a", 1, 8'h12, 0, 0, 0);
        cyc("t1b", 1, 8'h34, 0, 0, 0);
        check("t1.avail16", 32'(win_avail), 32'd16);
        check("t1.win1234", 32'(win_data), 32'h1234);
        cyc("t1c", 1, 8'h56, 0, 0, 0);
        check("t1.ready_at24", 32'(in_ready), 32'd1);
        cyc("t1d", 1, 8'h78, 0, 0, 0);
        check("t1.avail32", 32'(win_avail), 32'd32);
        check("t1.ready_at32", 32'(in_ready), 32'd0);
        cyc("t1e_blocked", 1, 8'h9A, 0, 0, 0);
        check("t1.still32", 32'(win_avail), 32'd32);
        drain("t1drain");

        // Stuffed 0xFF00 becomes a single 0xFF
        cyc("t2a", 1, 8'hFF, 0, 0, 0);
        cyc("t2b", 1, 8'h00, 0, 0, 0);
        cyc("t2c", 1, 8'hA5, 0, 0, 0);
        check("t2.avail16", 32'(win_avail), 32'd16);
        check("t2.winFFA5", 32'(win_data), 32'hFFA5);
        drain("t2drain");

        // Fill byte then EOI marker; buffered bits stay consumable
        cyc("t3a", 1, 8'hAB, 0, 0, 0);
        cyc("t3b", 1, 8'hFF, 0, 0, 0);
        cyc("t3c", 1, 8'hFF, 0, 0, 0);
        cyc("t3d", 1, 8'hD9, 0, 0, 0);
        check("t3.avail8", 32'(win_avail), 32'd8);
        check("t3.winAB", 32'(win_data), 32'hAB00);
        check("t3.mvalid", 32'(marker_valid), 32'd1);
        check("t3.mcodeD9", 32'(marker_code), 32'hD9);
        check("t3.ready0", 32'(in_ready), 32'd0);
        cyc("t3e", 0, 8'h00, 1, 8, 0);
        check("t3.avail0", 32'(win_avail), 32'd0);
        cyc("t3f", 0, 8'h00, 1, 4, 1);
        check("t3.mvalid_clr", 32'(marker_valid), 32'd0);
        check("t3.ready1", 32'(in_ready), 32'd1);
        check("t3.ack_no_err", 32'(protocol_err), 32'd0);

        // Same-cycle consume and append
        cyc("t4a", 1, 8'hC3, 0, 0, 0);
        cyc("t4b", 1, 8'hF0, 0, 0, 0);
        check("t4.winC3F0", 32'(win_data), 32'hC3F0);
        cyc("t4c", 1, 8'h55, 1, 3, 0);
        check("t4.avail21", 32'(win_avail), 32'd21);
        check("t4.win1F82", 32'(win_data), 32'h1F82);
        cyc("t4d", 0, 8'h00, 1, 0, 0);
        check("t4.len0_noop", 32'(win_avail), 32'd21);

        // Illegal consume is ignored and flags a sticky error
        cyc("t5a", 0, 8'h00, 1, 16, 0);
        cyc("t5b", 0, 8'h00, 1, 1, 0);
        check("t5.avail4", 32'(win_avail), 32'd4);
        cyc("t5c", 0, 8'h00, 1, 5, 0);
        check("t5.err", 32'(protocol_err), 32'd1);
        check("t5.unchanged", 32'(win_avail), 32'd4);
        cyc("t5d", 0, 8'h00, 0, 0, 0);
        check("t5.err_sticky", 32'(protocol_err), 32'd1);
        cyc("t5e", 1, 8'hFF, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all("t5.async_reset");
        check("t5.rst_avail0", 32'(win_avail), 32'd0);
        check("t5.rst_err0", 32'(protocol_err), 32'd0);
        check("t5.rst_code0", 32'(marker_code), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("t5.release");
        cyc("t5f", 0, 8'h00, 0, 0, 0);

        // RST3 marker with 13 buffered bits
        cyc("t6a", 1, 8'h12, 0, 0, 0);
        cyc("t6b", 1, 8'h34, 0, 0, 0);
        cyc("t6c", 0, 8'h00, 1, 3, 0);
        check("t6.avail13", 32'(win_avail), 32'd13);
        cyc("t6d", 1, 8'hFF, 0, 0, 0);
        cyc("t6e", 1, 8'hD3, 0, 0, 0);
`ifdef JPEG_RST_MARKER_PASS_EN
        check("t6.rst_seen", 32'(rst_seen), 32'd1);
        check("t6.rst_idx3", 32'(rst_idx), 32'd3);
        check("t6.avail8", 32'(win_avail), 32'd8);
        check("t6.win3400", 32'(win_data), 32'h3400);
        check("t6.no_stall", 32'(in_ready), 32'd1);
        cyc("t6f", 0, 8'h00, 0, 0, 0);
        check("t6.pulse_once", 32'(rst_seen), 32'd0);
`else
        check("t6.mvalid", 32'(marker_valid), 32'd1);
        check("t6.mcodeD3", 32'(marker_code), 32'hD3);
        check("t6.avail13_hold", 32'(win_avail), 32'd13);
        cyc("t6f", 0, 8'h00, 0, 0, 1);
        check("t6.released", 32'(marker_valid), 32'd0);
`endif
        drain("t6drain");

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            int r, mx, len;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            if (r <= 2)      b = 8'hFF;
            else if (r == 3) b = 8'h00;
            else if (r == 4) b = 8'hD9;
            else if (r == 5) b = 8'hD0 + 8'($urandom_range(0, 7));
            else             b = 8'($urandom);
            mx  = (q.size() < 16) ? q.size() : 16;
            len = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 16) : $urandom_range(0, mx);
            cyc("rand", $urandom_range(0, 3) != 0, b, $urandom_range(0, 1) == 1, len,
                $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
